seq_lock_detector: RTL and testbench
====================================

Name: seq_lock_detector

Overview:
- Receive-side counterpart of the team's serial sequence generators: consumes the repeating serial pattern (default 100111, MSB first) and detects it.
- Achieves frame lock after consecutive aligned periods and counts bit errors while locked.
- Declares loss of lock after repeated bad periods.
- Sits at the sink end of any serial-sequence link, e.g. loopback checking of a generator output.

Parameters:
- SEQ_LEN, 6, pattern length in bits (3..16)
- SEQ, 6'b100111, expected pattern; bit SEQ_LEN-1 is transmitted first
- LOCK_CNT, 3, consecutive aligned matching periods needed to enter LOCKED (>=1)
- UNLOCK_CNT, 2, consecutive errored periods that drop LOCKED (>=1)
- ERR_W, 8, width of error counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  din is sampled only when high
- din  in  1  serial data bit
- match  out  1  one-cycle pulse: last SEQ_LEN accepted bits equal SEQ
- locked  out  1  high while FSM in LOCKED
- phase  out  $clog2(SEQ_LEN)  index of next expected bit within the period; 0 when not LOCKED
- bit_err  out  1  one-cycle pulse: accepted bit differed from expected while LOCKED
- err_cnt  out  ERR_W  saturating count of bit_err pulses since last lock entry

Behaviour:
- Reset: clk and rst only; synchronous, active-high. The reset value of every output is 0: match=0, locked=0, phase=0, bit_err=0, err_cnt=0. Window, fill counter, FSM (→SEARCH), good and miss counters are also cleared.
- Reset mid-operation clears everything at that edge; no partial state survives.
- Bit acceptance: only edges with din_valid=1. With din_valid=0, all state holds and match/bit_err are 0 next cycle.
- Window: hist <= {hist[SEQ_LEN-2:0], din}. A fill counter saturates at SEQ_LEN; compare is enabled only once the window holds SEQ_LEN accepted bits.
- All outputs are registered. match and bit_err assert in the cycle after the accepting edge (latency 1). Overlapping matches are allowed.
- FSM states: SEARCH, VERIFY, LOCKED.
- SEARCH:
  - on accepted bit completing a match → VERIFY, with pos=0 and good=1.
  - LOCK_CNT=1 goes directly to LOCKED.
- VERIFY:
  - pos counts accepted bits mod SEQ_LEN.
  - At each wrap (pos returns to 0), check match. If it matches: good++; when good==LOCK_CNT → LOCKED, err_cnt=0, miss=0. If it does not match → SEARCH, good=0.
  - Non-wrap bits are not checked.
- LOCKED:
  - Each accepted bit is compared with SEQ[SEQ_LEN-1-pos]. A mismatch pulses bit_err, err_cnt increments and saturates at all-ones, and the period-error flag is set.
  - At wrap: an errored period gives miss++; a clean period gives miss=0. When miss==UNLOCK_CNT → SEARCH, with locked low the next cycle and good/miss cleared.
  - err_cnt holds its value in SEARCH/VERIFY until the next lock entry.
- phase = pos while LOCKED, else 0.
- A simultaneous wrap and bit error counts the error in the closing period first, then evaluates miss.

Optional Feature:
- Macro: SEQ_LOCK_DETECTOR_ERRCNT_EN.
- Defined: err_cnt implemented as above.
- Undefined: err_cnt counter logic is removed and the port is tied to 0. bit_err, miss tracking and lock behaviour are unchanged.

Decomposition:
- Package seq_lock_pkg:
  - state enum {SEARCH, VERIFY, LOCKED}
  - default SEQ constant 6'b100111
  - function clog2-based phase width helper
- One sub-module, seq_window_cmp: shift register, fill counter and compare. Output is a raw combinational match_raw, which the top registers into match.

Test Plan:
- Reset, then feed 100111 repeated (valid every cycle) → match pulses 1 cycle after the 6th, 12th and 18th bits; locked=1 after the 18th bit's edge; phase cycles 0..5.
- Prefix 0110 then the repeated pattern → first match only after a full pattern is received; locked after 3 aligned periods; err_cnt=0.
- Once locked, flip 1 bit in one period → single bit_err pulse, err_cnt=1, locked stays 1; flip bits in 2 consecutive periods → locked drops after the second period's wrap.
- din_valid toggling 1/0 every cycle with the pattern on valid cycles → same lock result as the continuous run, at half rate; no pulses on invalid cycles.
- Assert rst while LOCKED with err_cnt=5 → next cycle all outputs 0 and FSM in SEARCH; the pattern relocks after 18 bits.
- Build without SEQ_LOCK_DETECTOR_ERRCNT_EN, inject errors → bit_err pulses and err_cnt stays 0.

Source files
------------

// File: rtl/seq_lock_pkg.sv
// Shared types and constants for the serial sequence lock detector.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_e;

  localparam int unsigned DEF_SEQ_LEN = 6;
  localparam logic [DEF_SEQ_LEN-1:0] DEF_SEQ = 6'b100111;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned phase_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Serial history window with fill tracking; flags (combinationally) when the
// bit being accepted completes a window equal to SEQ.
module seq_window_cmp
  import seq_lock_pkg::*;
#(
  parameter int unsigned          SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0]   SEQ     = DEF_SEQ
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic din,
  output logic match_raw
);

  localparam int unsigned FW = $clog2(SEQ_LEN + 1);

  // Only SEQ_LEN-1 past bits are stored; the incoming bit completes the window.
  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (accept) begin
      hist_d = {hist_q[SEQ_LEN-3:0], din};
      if (fill_q != FW'(SEQ_LEN)) fill_d = fill_q + 1'b1;
    end
  end

  assign match_raw = accept && (fill_q >= FW'(SEQ_LEN - 1)) && ({hist_q, din} == SEQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_lock_detector.sv
// Frame-lock detector for a repeating serial pattern with bit-error counting.
// Define SEQ_LOCK_DETECTOR_ERRCNT_EN to build the err_cnt counter; otherwise err_cnt is 0.
module seq_lock_detector
  import seq_lock_pkg::*;
#(
  parameter int unsigned        SEQ_LEN    = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ        = DEF_SEQ,
  parameter int unsigned        LOCK_CNT   = 3,
  parameter int unsigned        UNLOCK_CNT = 2,
  parameter int unsigned        ERR_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_valid,
  input  logic                        din,
  output logic                        match,
  output logic                        locked,
  output logic [phase_w(SEQ_LEN)-1:0] phase,
  output logic                        bit_err,
  output logic [ERR_W-1:0]            err_cnt
);

  localparam int unsigned PW = phase_w(SEQ_LEN);
  localparam int unsigned GW = phase_w(LOCK_CNT + 1);
  localparam int unsigned MW = phase_w(UNLOCK_CNT + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_inc, exp_idx;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          per_err_q, per_err_d;
  logic          match_q, bit_err_q, bit_err_d;
  logic          match_raw, wrap, exp_bit, err_inc, err_clr;

  seq_window_cmp #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ     (SEQ)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .accept    (din_valid),
    .din       (din),
    .match_raw (match_raw)
  );

  assign wrap    = (pos_q == PW'(SEQ_LEN - 1));
  assign pos_inc = wrap ? '0 : pos_q + 1'b1;
  assign exp_idx = PW'(SEQ_LEN - 1) - pos_q;
  assign exp_bit = SEQ[exp_idx];

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    good_d    = good_q;
    miss_d    = miss_q;
    per_err_d = per_err_q;
    bit_err_d = 1'b0;
    err_inc   = 1'b0;
    err_clr   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (match_raw) begin
            pos_d     = '0;
            per_err_d = 1'b0;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              miss_d  = '0;
              err_clr = 1'b1;
            end else begin
              state_d = VERIFY;
              good_d  = GW'(1);
            end
          end
        end
        VERIFY: begin
          pos_d = pos_inc;
          if (wrap) begin
            if (match_raw) begin
              good_d = good_q + 1'b1;
              if (good_d == GW'(LOCK_CNT)) begin
                state_d   = LOCKED;
                miss_d    = '0;
                per_err_d = 1'b0;
                err_clr   = 1'b1;
              end
            end else begin
              state_d = SEARCH;
              good_d  = '0;
            end
          end
        end
        LOCKED: begin
          pos_d     = pos_inc;
          bit_err_d = (din != exp_bit);
          err_inc   = bit_err_d;
          per_err_d = per_err_q | bit_err_d;
          // The bit closing a period contributes to that period's verdict.
          if (wrap) begin
            per_err_d = 1'b0;
            miss_d    = (per_err_q | bit_err_d) ? miss_q + 1'b1 : '0;
            if (miss_d == MW'(UNLOCK_CNT)) begin
              state_d = SEARCH;
              good_d  = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      pos_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      per_err_q <= 1'b0;
      match_q   <= 1'b0;
      bit_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      per_err_q <= per_err_d;
      match_q   <= match_raw;
      bit_err_q <= bit_err_d;
    end
  end

`ifdef SEQ_LOCK_DETECTOR_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)                          err_cnt_d = '0;
    else if (err_inc && err_cnt_q != '1)  err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err;
  assign unused_err = ^{err_inc, err_clr};
  assign err_cnt    = '0;
`endif

  assign match   = match_q;
  assign bit_err = bit_err_q;
  assign locked  = (state_q == LOCKED);
  assign phase   = locked ? pos_q : '0;

endmodule

// File: tb/tb_seq_lock_detector.sv
// Directed scoreboard bench for seq_lock_detector against a behavioural reference model.
module tb_seq_lock_detector;

  localparam int unsigned L     = 6;
  localparam logic [5:0]  PAT   = 6'b100111;
  localparam int          LOCKN = 3;
  localparam int          UNL   = 2;
`ifdef SEQ_LOCK_DETECTOR_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic       clk, rst, din_valid, din;
  logic       match, locked, bit_err;
  logic [2:0] phase;
  logic [7:0] err_cnt;

  seq_lock_detector #(
    .SEQ_LEN    (6),
    .SEQ        (6'b100111),
    .LOCK_CNT   (3),
    .UNLOCK_CNT (2),
    .ERR_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .match     (match),
    .locked    (locked),
    .phase     (phase),
    .bit_err   (bit_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit m;
    bit lk;
    int ph;
    bit be;
    int ec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: 0 = search, 1 = verify, 2 = locked.
  int m_state, m_pos, m_good, m_miss, m_errc, m_fill;
  bit m_perr;
  bit [5:0] m_hist;

  task automatic model(input bit r, input bit v, input bit d, output exp_t e);
    bit mt, be, wrapped;
    mt = 0;
    be = 0;
    if (r) begin
      m_state = 0; m_pos = 0; m_good = 0; m_miss = 0; m_errc = 0;
      m_fill = 0; m_perr = 0; m_hist = '0;
    end else if (v) begin
      m_hist = {m_hist[4:0], d};
      if (m_fill < L) m_fill++;
      mt = (m_fill == L) && (m_hist == PAT);
      if (m_state == 0) begin
        if (mt) begin
          m_state = 1; m_pos = 0; m_good = 1;
        end
      end else if (m_state == 1) begin
        wrapped = (m_pos == L - 1);
        m_pos = (m_pos + 1) % L;
        if (wrapped) begin
          if (mt) begin
            m_good++;
            if (m_good == LOCKN) begin
              m_state = 2; m_errc = 0; m_miss = 0; m_perr = 0;
            end
          end else begin
            m_state = 0; m_good = 0;
          end
        end
      end else begin
        be = (d != PAT[L-1-m_pos]);
        if (be && m_errc < 255) m_errc++;
        if (be) m_perr = 1;
        wrapped = (m_pos == L - 1);
        m_pos = (m_pos + 1) % L;
        if (wrapped) begin
          m_miss = m_perr ? m_miss + 1 : 0;
          m_perr = 0;
          if (m_miss == UNL) begin
            m_state = 0; m_good = 0; m_miss = 0;
          end
        end
      end
    end
    e.m  = mt;
    e.be = be;
    e.lk = (m_state == 2);
    e.ph = (m_state == 2) ? m_pos : 0;
    e.ec = ERRCNT_ON ? m_errc : 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit d);
    exp_t e;
    @(negedge clk);
    rst       = r;
    din_valid = v;
    din       = d;
    model(r, v, d, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("match",   match,   32'(e.m));
    check("locked",  locked,  32'(e.lk));
    check("phase",   phase,   32'(e.ph));
    check("bit_err", bit_err, 32'(e.be));
    check("err_cnt", err_cnt, 32'(e.ec));
  endtask

  // One pattern period, MSB first; set bits of flip invert the matching pattern bits.
  task automatic feed_period(input logic [5:0] flip, input bit half);
    for (int i = 0; i < L; i++) begin
      bit b;
      b = PAT[L-1-i] ^ flip[L-1-i];
      if (half) step(0, 0, 1'($urandom_range(0, 1)));
      step(0, 1, b);
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 1'b0;
    step(1, 0, 0);
    step(1, 1, 1);

    // Continuous pattern: lock after the third aligned period, phase cycles.
    repeat (4) feed_period(6'b000000, 0);
    // Single errored period keeps lock; two consecutive errored periods drop it.
    feed_period(6'b000100, 0);
    feed_period(6'b000000, 0);
    feed_period(6'b010000, 0);
    feed_period(6'b000001, 0);
    repeat (2) feed_period(6'b000000, 0);

    // Misaligned prefix, then relock.
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
    repeat (4) feed_period(6'b000000, 0);
    repeat (3) step(0, 0, 0);

    // Half-rate valid.
    step(1, 0, 0);
    repeat (4) feed_period(6'b000000, 1);
    step(0, 0, 1);

    // Five errors in one period, a clean period, then reset while locked.
    feed_period(6'b111011, 0);
    feed_period(6'b000000, 0);
    feed_period(6'b000000, 0);
    step(1, 1, 1);
    repeat (4) feed_period(6'b000000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
